// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset core: fetch, decode, execute and retire one instruction per enabled edge.
// Optional macro CPU_MUL_EN adds R-type funct 0x18 (mul, low 32 bits of the signed product).

module pc_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q = '0;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q <= '0;
        end else if (en_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_o = pc_q;
endmodule

module instruction_memory #(
    parameter int DEPTH = 256
) (
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [31:0]              instr_o
);
    // Contents are loaded externally; the zero fill only gives a defined power-up image.
    logic [31:0] memory [0:DEPTH-1] = '{default: '0};

    assign instr_o = memory[addr_i];
endmodule

module register_file (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] register [0:31];

    // NOTE: storage arrays get no reset, so they map onto RAM/plain flops without a reset tree.
    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            register[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : register[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : register[ra2_i];
endmodule

module cpu #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
`ifdef CPU_MUL_EN
    localparam logic [5:0] FN_MUL = 6'h18;
`endif

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
`ifdef CPU_MUL_EN
        , ALU_MUL
`endif
    } alu_op_e;

    logic [31:0] pc, pc_d, pc_plus4, branch_target, jump_target;
    logic [31:0] instr, simm;
    logic [31:0] rd1, rd2, alu_b, alu_res, dmem_rdata, wd;
    logic [4:0]  wa;
    logic        run;
    logic        reg_we, mem_we, mem_to_reg, alu_src_imm, dst_rd, branch, jump;
    alu_op_e     alu_op;
    logic [31:0]        dmem_q [0:DMEM_DEPTH-1];
    logic [DMEM_AW-1:0] dmem_addr;

    assign run = rst_i & start_i;

    pc_reg PC (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (start_i),
        .pc_d_i (pc_d),
        .pc_o   (pc)
    );

    instruction_memory #(.DEPTH(IMEM_DEPTH)) Instruction_Memory (
        .addr_i  (pc[IMEM_AW+1:2]),
        .instr_o (instr)
    );

    always_comb begin
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        dst_rd      = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_op      = ALU_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                dst_rd = 1'b1;
                case (instr[5:0])
                    FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
`ifdef CPU_MUL_EN
                    FN_MUL: begin reg_we = 1'b1; alu_op = ALU_MUL; end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin reg_we = 1'b1; alu_src_imm = 1'b1; end
            OP_LW:   begin reg_we = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin mem_we = 1'b1; alu_src_imm = 1'b1; end
            OP_BEQ:  branch = 1'b1;
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign simm  = {{16{instr[15]}}, instr[15:0]};
    assign wa    = dst_rd ? instr[15:11] : instr[20:16];
    assign wd    = mem_to_reg ? dmem_rdata : alu_res;

    register_file Registers (
        .clk_i (clk_i),
        .we_i  (reg_we & run),
        .ra1_i (instr[25:21]),
        .ra2_i (instr[20:16]),
        .wa_i  (wa),
        .wd_i  (wd),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign alu_b = alu_src_imm ? simm : rd2;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = rd1 + alu_b;
            ALU_SUB: alu_res = rd1 - alu_b;
            ALU_AND: alu_res = rd1 & alu_b;
            ALU_OR:  alu_res = rd1 | alu_b;
`ifdef CPU_MUL_EN
            ALU_MUL: alu_res = $signed(rd1) * $signed(alu_b);
`endif
            default: alu_res = '0;
        endcase
    end

    // Word address wraps within the data memory; upper address bits are ignored.
    assign dmem_addr  = alu_res[DMEM_AW+1:2];
    assign dmem_rdata = dmem_q[dmem_addr];

    always_ff @(posedge clk_i) begin
        if (run && mem_we) begin
            dmem_q[dmem_addr] <= rd2;
        end
    end

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        if (jump) begin
            pc_d = jump_target;
        end else if (branch && (rd1 == rd2)) begin
            pc_d = branch_target;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: programs are preloaded into instruction memory,
// PC and registers are observed hierarchically.

module tb_cpu;
    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog[$];

    cpu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] funct, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    function automatic logic [31:0] rf(input int idx);
        return dut.Registers.register[idx];
    endfunction

    function automatic logic [31:0] pc();
        return dut.PC.pc_o;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) dut.Instruction_Memory.memory[i] = prog[i];
    endtask

    // Reset PC while stalled, load the program, then retire exactly n instructions.
    task automatic run_prog(input int n);
        rst_i   = 1'b0;
        start_i = 1'b0;
        tick(1);
        load_prog();
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick(n);
        start_i = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;

        // Reset and stall behaviour
        prog = '{i_type(6'h08, 5'd0, 5'd1, 16'd77),
                 i_type(6'h08, 5'd0, 5'd2, 16'd5),
                 i_type(6'h08, 5'd0, 5'd3, 16'd6)};
        load_prog();
        tick(2);
        check("pc_in_reset", pc(), 32'd0);
        rst_i = 1'b1;
        tick(3);
        check("pc_stalled", pc(), 32'd0);
        start_i = 1'b1;
        tick(1);
        check("pc_step1", pc(), 32'd4);
        tick(1);
        check("pc_step2", pc(), 32'd8);
        tick(1);
        check("pc_step3", pc(), 32'd12);
        start_i = 1'b0;
        check("r1_first", rf(1), 32'd77);
        check("r2_first", rf(2), 32'd5);
        check("r3_first", rf(3), 32'd6);

        dut.Instruction_Memory.memory[3] = i_type(6'h08, 5'd0, 5'd1, 16'd99);
        tick(3);
        check("pc_stall_hold", pc(), 32'd12);
        check("r1_stall_hold", rf(1), 32'd77);

        dut.Instruction_Memory.memory[0] = i_type(6'h08, 5'd0, 5'd1, 16'd55);
        rst_i   = 1'b0;
        start_i = 1'b1;
        tick(2);
        check("pc_reset_over_start", pc(), 32'd0);
        check("r1_no_write_in_reset", rf(1), 32'd77);
        start_i = 1'b0;
        rst_i   = 1'b1;

        // Arithmetic
        prog = '{i_type(6'h08, 5'd0, 5'd8, 16'd10),
                 i_type(6'h08, 5'd0, 5'd9, 16'hFFFD),
                 r_type(6'h20, 5'd10, 5'd8, 5'd9),
                 r_type(6'h22, 5'd11, 5'd8, 5'd9),
                 r_type(6'h24, 5'd12, 5'd8, 5'd9),
                 r_type(6'h25, 5'd13, 5'd8, 5'd9)};
        run_prog(6);
        check("addi_r8", rf(8), 32'd10);
        check("addi_neg_r9", rf(9), 32'hFFFF_FFFD);
        check("add_r10", rf(10), 32'd7);
        check("sub_r11", rf(11), 32'd13);
        check("and_r12", rf(12), 32'd8);
        check("or_r13", rf(13), 32'hFFFF_FFFF);
        check("pc_arith", pc(), 32'd24);

        // Register 0 protection
        prog = '{i_type(6'h08, 5'd0, 5'd0, 16'd5)};
        run_prog(1);
        check("r0_array", rf(0), 32'd0);
        check("pc_r0", pc(), 32'd4);
        prog = '{i_type(6'h08, 5'd0, 5'd0, 16'd5),
                 r_type(6'h20, 5'd14, 5'd0, 5'd0)};
        run_prog(2);
        check("r0_read_zero", rf(14), 32'd0);

        // Data memory, including address wrap
        prog = '{i_type(6'h08, 5'd0, 5'd8, 16'd44),
                 i_type(6'h2B, 5'd0, 5'd8, 16'd4),
                 i_type(6'h23, 5'd0, 5'd9, 16'd4),
                 i_type(6'h08, 5'd0, 5'd8, 16'd123),
                 i_type(6'h2B, 5'd0, 5'd8, 16'd132),
                 i_type(6'h23, 5'd0, 5'd10, 16'd4)};
        run_prog(6);
        check("lw_r9", rf(9), 32'd44);
        check("lw_wrap_r10", rf(10), 32'd123);
        check("pc_mem", pc(), 32'd24);

        // Control flow
        prog = '{i_type(6'h04, 5'd0, 5'd0, 16'd2)};
        run_prog(1);
        check("beq_taken", pc(), 32'd12);
        prog = '{i_type(6'h04, 5'd8, 5'd0, 16'd2)};
        run_prog(1);
        check("beq_not_taken", pc(), 32'd4);
        prog = '{j_type(26'd5)};
        run_prog(1);
        check("jump", pc(), 32'd20);

        prog.delete();
        run_prog(256);
        check("pc_past_255", pc(), 32'd1024);
        dut.Instruction_Memory.memory[0] = i_type(6'h08, 5'd0, 5'd15, 16'd33);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        check("imem_wrap_exec", rf(15), 32'd33);
        check("pc_after_wrap", pc(), 32'd1028);

        // Multiply (optional) and an unlisted funct acting as NOP
        prog = '{i_type(6'h08, 5'd0, 5'd8, 16'hFFFA),
                 i_type(6'h08, 5'd0, 5'd9, 16'd7),
                 i_type(6'h08, 5'd0, 5'd10, 16'd1),
                 i_type(6'h08, 5'd0, 5'd11, 16'd2),
                 r_type(6'h18, 5'd10, 5'd8, 5'd9),
                 r_type(6'h26, 5'd11, 5'd8, 5'd9)};
        run_prog(6);
`ifdef CPU_MUL_EN
        check("mul_r10", rf(10), 32'hFFFF_FFD6);
`else
        check("mul_nop_r10", rf(10), 32'd1);
`endif
        check("funct_nop_r11", rf(11), 32'd2);
        check("pc_mul", pc(), 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
